pipe_reg_mux: RTL and testbench
===============================

Name: pipe_reg_mux

Overview:
- Parametrised successor to the single-stage DSP48A1 input register/bypass mux.
- Configurable data width and pipeline depth (0 = pure bypass), with a valid bit carried through every stage.
- Stall via clock enable; synchronous flush; registered occupancy count.
- Used on the A/B/C/D/M/P paths where more than one pipeline stage, or valid tracking, is needed.

Parameters:
- WIDTH, 18: data width in bits (1..48).
- DEPTH, 1: number of register stages (0..8). 0 = combinational bypass.
- OCC_W, 4: occupancy counter width. Must be at least clog2(DEPTH+1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- CE  input  1  clock enable / stall. 1 = advance pipeline; 0 = hold all stages.
- SRST  input  1  synchronous flush, active-high. Priority over CE.
- in_data  input  WIDTH  data into stage 0.
- in_valid  input  1  qualifies in_data.
- out_data  output  WIDTH  data from the last stage.
- out_valid  output  1  valid from the last stage.
- occ  output  OCC_W  number of stages currently holding valid data.
- par_err  output  1  parity error flag (see Optional Feature).

Behaviour:
- Reset (RST=0): asynchronous. All data stages = 0, all valid bits = 0, occ = 0, par_err = 0. Takes effect immediately and holds while low; independent of CLK, CE and SRST.
- First edge after RST deasserts: normal operation. No extra recovery cycle.
- Rising edge with SRST=1: all data stages = 0, valid = 0, occ = 0, par_err = 0, regardless of CE or in_valid. The input on that edge is discarded.
- Rising edge with SRST=0 and CE=1:
  - stage[0] <= {in_valid, in_data}.
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - Data registers load even when in_valid=0. Valid bits gate meaning only.
- Rising edge with SRST=0 and CE=0: every stage, occ and par_err hold.
- Outputs: out_data/out_valid = stage[DEPTH-1].
- Latency: exactly DEPTH CE-enabled edges from input to output. CE=0 edges do not count.
- DEPTH=0:
  - out_data = in_data and out_valid = in_valid, combinationally.
  - occ = 0 constant; par_err = 0 constant.
  - CE, SRST and CLK are unused.
- occ (registered, DEPTH>=1):
  - On a CE=1, SRST=0 edge: occ <= occ + in_valid - stage[DEPTH-1].valid.
  - Range 0..DEPTH. Cannot wrap by construction.
  - Simultaneous enter and leave leaves occ unchanged.
  - Invariant: occ always equals the popcount of the stage valid bits. Verify with an assertion.
- No backpressure: the pipeline never refuses input. The upstream block must honour CE.
- Parameter check: DEPTH > 8, or OCC_W < clog2(DEPTH+1), is a fatal elaboration error.

Optional Feature:
- Macro: PIPE_REG_MUX_PARITY_EN.
- Defined:
  - Each stage carries an extra parity bit, set to the XOR-reduction of in_data when loaded into stage 0.
  - The parity bit shifts with the data under the same CE/SRST/RST rules.
  - On a CE=1, SRST=0 edge where the last stage is valid and XOR(out_data) differs from the stored parity, par_err <= 1.
  - par_err is sticky; cleared only by RST or SRST.
- Not defined: no parity storage; par_err tied to 0.

Test Plan:
- Reset: drive RST=0 mid-stream with DEPTH=3, WIDTH=18 and three valid words in flight -> out_data=0, out_valid=0, occ=0 immediately, without waiting for a clock edge.
- Latency: DEPTH=3, CE=1, inject 0x2A5A5 valid at edge 0 -> out_data=0x2A5A5 with out_valid=1 after edge 3. Word sequence 1..10 emerges in order.
- Stall: DEPTH=3, in_valid=1 on 3 consecutive edges, then CE=0 for 5 edges with in_data changing -> out_data, occ (=3) and out_valid frozen. Resume CE=1 -> remaining words emerge in order.
- Flush vs CE: occ=2, assert SRST=1 with CE=0 and in_valid=1 -> next edge occ=0, out_valid=0. Input on that edge discarded.
- Bypass: DEPTH=0, in_data=0x3FFFF, in_valid=1 -> out_data=0x3FFFF and out_valid=1 in the same delta. occ=0. Toggling CE/SRST has no effect.
- Parity (macro defined): DEPTH=2, force-flip bit 0 of stage[1] data -> par_err=1 on the next enabled edge and stays 1 until SRST=1.

Source files
------------

// File: rtl/pipe_reg_mux.sv
// pipe_reg_mux: parametrised DSP input register / bypass pipeline
// with valid tracking, CE stall, sync flush, occupancy count and
// optional parity (PIPE_REG_MUX_PARITY_EN).
// Ports: CLK, RST (async active-low), CE (advance), SRST (flush),
//   in_data/in_valid -> stage 0; out_data/out_valid <- last stage;
//   occ = valid stages held; par_err = sticky parity error.
module pipe_reg_mux #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1,
  parameter int OCC_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             SRST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [OCC_W-1:0] occ,
  output logic             par_err
);

  if (DEPTH > 8 || DEPTH < 0 ||
      OCC_W < $clog2(DEPTH + 1)) begin : g_bad
    $fatal(1, "pipe_reg_mux: bad DEPTH/OCC_W");
  end

  if (DEPTH == 0) begin : g_byp
    logic unused_b;
    assign unused_b  = ^{CLK, RST, CE, SRST};
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign occ       = '0;
    assign par_err   = 1'b0;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [OCC_W-1:0]            occ_q, occ_d;

    always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      occ_d  = occ_q;
      if (SRST) begin
        data_d = '0;
        vld_d  = '0;
        occ_d  = '0;
      end else if (CE) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          data_d[k] = data_q[k-1];
          vld_d[k]  = vld_q[k-1];
        end
        data_d[0] = in_data;
        vld_d[0]  = in_valid;
        // enter and leave in the same edge cancel out
        occ_d = occ_q + OCC_W'(in_valid)
                      - OCC_W'(vld_q[DEPTH-1]);
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        data_q <= '0;
        vld_q  <= '0;
        occ_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
        occ_q  <= occ_d;
      end
    end

    always_comb begin
      assert (occ_q == OCC_W'($countones(vld_q)));
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];
    assign occ       = occ_q;

`ifdef PIPE_REG_MUX_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             par_err_q, par_err_d;

    always_comb begin
      par_d     = par_q;
      par_err_d = par_err_q;
      if (SRST) begin
        par_d     = '0;
        par_err_d = 1'b0;
      end else if (CE) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          par_d[k] = par_q[k-1];
        end
        par_d[0] = ^in_data;
        // only a valid word leaving the last stage is judged
        if (vld_q[DEPTH-1] &&
            ((^data_q[DEPTH-1]) != par_q[DEPTH-1])) begin
          par_err_d = 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        par_q     <= '0;
        par_err_q <= 1'b0;
      end else begin
        par_q     <= par_d;
        par_err_q <= par_err_d;
      end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pipe_reg_mux.sv
// tb_pipe_reg_mux: directed scoreboard bench for pipe_reg_mux
// (DEPTH=3 pipeline plus DEPTH=0 bypass instance).
module tb_pipe_reg_mux;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic        SRST;
  logic [17:0] in_data;
  logic        in_valid;
  logic [17:0] out_data;
  logic        out_valid;
  logic [3:0]  occ;
  logic        par_err;

  logic        b_ce;
  logic        b_srst;
  logic [17:0] b_in_data;
  logic        b_in_valid;
  logic [17:0] b_out_data;
  logic        b_out_valid;
  logic [3:0]  b_occ;
  logic        b_par_err;

  int checks = 0;
  int errors = 0;

  logic [17:0] q[$];
  logic [2:0]  mv;
  logic [17:0] held;

  pipe_reg_mux #(.WIDTH(18), .DEPTH(3), .OCC_W(4)) u_dut (
    .CLK(CLK), .RST(RST), .CE(CE), .SRST(SRST),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid),
    .occ(occ), .par_err(par_err)
  );

  pipe_reg_mux #(.WIDTH(18), .DEPTH(0), .OCC_W(4)) u_byp (
    .CLK(CLK), .RST(RST), .CE(b_ce), .SRST(b_srst),
    .in_data(b_in_data), .in_valid(b_in_valid),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .occ(b_occ), .par_err(b_par_err)
  );

`ifdef PIPE_REG_MUX_PARITY_EN
  logic [17:0] p_out_data;
  logic        p_out_valid;
  logic [3:0]  p_occ;
  logic        p_par_err;

  pipe_reg_mux #(.WIDTH(18), .DEPTH(2), .OCC_W(4)) u_par (
    .CLK(CLK), .RST(RST), .CE(CE), .SRST(SRST),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(p_out_data), .out_valid(p_out_valid),
    .occ(p_occ), .par_err(p_par_err)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic ce, input logic srst,
                      input logic vld, input logic [17:0] d);
    CE = ce;
    SRST = srst;
    in_valid = vld;
    in_data = d;
    @(posedge CLK);
    #1;
    if (srst) begin
      mv = '0;
      q.delete();
      check("flush_data", 32'(out_data), 32'h0);
    end else if (ce) begin
      if (vld) q.push_back(d);
      mv = {mv[1:0], vld};
      if (mv[2]) begin
        if (q.size() == 0) begin
          check("sb_underflow", 32'(q.size()), 32'h1);
        end else begin
          held = q.pop_front();
        end
      end
    end
    check("out_valid", 32'(out_valid), 32'(mv[2]));
    check("occ", 32'(occ), 32'($countones(mv)));
    check("par_err", 32'(par_err), 32'h0);
    if (mv[2]) check("out_data", 32'(out_data), 32'(held));
  endtask

  initial begin
    RST = 1'b0;
    CE = 1'b0;
    SRST = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    b_ce = 1'b0;
    b_srst = 1'b0;
    b_in_valid = 1'b0;
    b_in_data = '0;
    mv = '0;
    held = '0;
    #1;
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_occ", 32'(occ), 32'h0);
    check("rst_par", 32'(par_err), 32'h0);
    #2 RST = 1'b1;

    // latency of a single word
    step(1'b1, 1'b0, 1'b1, 18'h2A5A5);
    step(1'b1, 1'b0, 1'b0, 18'h00000);
    check("lat_early", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 18'h00000);
    check("lat_valid", 32'(out_valid), 32'h1);
    check("lat_data", 32'(out_data), 32'h2A5A5);
    step(1'b1, 1'b0, 1'b0, 18'h00000);

    // ordered stream 1..10 then drain
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b0, 1'b1, 18'(i));
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 18'h3FFFF);
    check("stream_empty", 32'(q.size()), 32'h0);

    // stall with changing input
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 18'h100 + 18'(i));
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 18'h2000 + 18'(i));
    check("stall_occ", 32'(occ), 32'h3);
    check("stall_data", 32'(out_data), 32'h100);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 18'h0);
    check("stall_empty", 32'(q.size()), 32'h0);

    // flush beats CE=0 and discards its input
    step(1'b1, 1'b0, 1'b1, 18'h11);
    step(1'b1, 1'b0, 1'b1, 18'h22);
    check("pre_flush_occ", 32'(occ), 32'h2);
    step(1'b0, 1'b1, 1'b1, 18'h33);
    check("flush_occ", 32'(occ), 32'h0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 18'h0);

    // async reset mid-cycle with three words in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 18'h500 + 18'(i));
    #3 RST = 1'b0;
    #1;
    check("arst_data", 32'(out_data), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_occ", 32'(occ), 32'h0);
    mv = '0;
    q.delete();
    #1 RST = 1'b1;
    step(1'b1, 1'b0, 1'b1, 18'h1ABCD);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 18'h0);

    // bypass instance
    b_in_data = 18'h3FFFF;
    b_in_valid = 1'b1;
    #1;
    check("byp_data", 32'(b_out_data), 32'h3FFFF);
    check("byp_valid", 32'(b_out_valid), 32'h1);
    check("byp_occ", 32'(b_occ), 32'h0);
    b_ce = 1'b1;
    b_srst = 1'b1;
    b_in_data = 18'h12345;
    @(posedge CLK);
    #1;
    check("byp_data2", 32'(b_out_data), 32'h12345);
    check("byp_valid2", 32'(b_out_valid), 32'h1);
    check("byp_par", 32'(b_par_err), 32'h0);
    b_in_valid = 1'b0;
    #1;
    check("byp_valid3", 32'(b_out_valid), 32'h0);

`ifdef PIPE_REG_MUX_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 18'h0);
    step(1'b1, 1'b0, 1'b1, 18'h5);
    step(1'b1, 1'b0, 1'b0, 18'h0);
    check("par_clean", 32'(p_par_err), 32'h0);
    u_par.g_pipe.data_q[1][0] = ~u_par.g_pipe.data_q[1][0];
    step(1'b1, 1'b0, 1'b0, 18'h0);
    check("par_set", 32'(p_par_err), 32'h1);
    step(1'b1, 1'b0, 1'b0, 18'h0);
    check("par_sticky", 32'(p_par_err), 32'h1);
    step(1'b0, 1'b1, 1'b0, 18'h0);
    check("par_clear", 32'(p_par_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
